inst_axi_bridge: RTL and testbench

- Instruction-side adapter directly upstream of the fetch stage.
- Converts the fetch stage's SRAM-like read interface (req / addr_ok / data_ok) into single-beat AXI3 read transactions.
- Returns instruction words in request order, with a bounded number of reads outstanding.
- The fetch stage handles cancellation itself, so the bridge returns exactly one data_ok for every accepted request.

---
 rtl/inst_axi_bridge_if.sv | 52 +++++
 rtl/inst_axi_bridge.sv | 102 ++++++++++
 tb/tb_inst_axi_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_bridge_if.sv
// Bus bundles for the instruction-fetch bridge: SRAM-like fetch port and AXI3 read channels.
// master = side that issues requests (fetch stage / bridge on AXI), slave = side that answers.
interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_axi_bridge.sv
// Instruction-side bridge: turns fetch-stage SRAM-like reads into single-beat AXI3 reads,
// returning words in request order with at most MAX_OUTSTANDING reads in flight.
module inst_axi_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  AXI_ARID        = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    inst_sram_if.slave sram,
    axi_rd_if.master   axi
);
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    typedef enum logic {AR_IDLE = 1'b0, AR_VALID = 1'b1} ar_state_e;

    ar_state_e   state, state_nxt;
    logic [1:0]  cnt;
    logic        accept;
    logic        r_hs;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        data_ok_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (reset) state <= AR_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AR_IDLE:  if (accept)      state_nxt = AR_VALID;
            AR_VALID: if (axi.arready) state_nxt = AR_IDLE;
            default:                   state_nxt = AR_IDLE;
        endcase
    end

    // Accepts are only taken while no AR is pending, so at most one address is ever held.
    always_comb begin
        accept      = 1'b0;
        axi.arvalid = 1'b0;
        case (state)
            AR_IDLE:  accept = sram.inst_sram_req & ~sram.inst_sram_wr & (cnt < MAX_CNT);
            AR_VALID: axi.arvalid = 1'b1;
            default:  ;
        endcase
    end

    assign r_hs      = axi.rvalid & axi.rready;
    assign axi.rready = (cnt != 2'd0);

    // r_hs implies cnt != 0 and accept implies cnt < MAX, so neither direction can wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
        end else begin
            case ({accept, r_hs})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= 32'd0;
            arsize_q <= 3'd0;
        end else if (accept) begin
            araddr_q <= sram.inst_sram_addr;
            arsize_q <= {1'b0, sram.inst_sram_size};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= r_hs;
            if (r_hs) rdata_q <= axi.rdata;
        end
    end

    assign sram.inst_sram_addr_ok = accept;
    assign sram.inst_sram_data_ok = data_ok_q;
    assign sram.inst_sram_rdata   = rdata_q;

    assign axi.arid    = AXI_ARID;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;

    // Response status and write-side fields carry no meaning for instruction fetch.
    logic unused_ok;
    assign unused_ok = ^{sram.inst_sram_wstrb, sram.inst_sram_wdata, axi.rid, axi.rresp, axi.rlast};
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Bench for inst_axi_bridge: AXI read slave model plus an in-order scoreboard of expected words.
module tb_inst_axi_bridge;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    inst_sram_if sram ();
    axi_rd_if    axi ();

    inst_axi_bridge #(.MAX_OUTSTANDING(2), .AXI_ARID(4'd0)) dut (
        .clk(clk), .reset(reset), .sram(sram), .axi(axi)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] drop_w;
    logic [31:0] exp_w;
    logic        r_hold = 1'b1;
    int          ar_hs_cnt = 0;
    int          r_hs_cnt = 0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a == 32'h1c00_0000) ? 32'h0280_0c0c : {a[15:0], ~a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AXI slave: answers each AR in order with rd_word(addr), one beat, unless r_hold.
    always @(posedge clk) begin
        if (reset) begin
            ar_q.delete();
        end else begin
            if (axi.rvalid && axi.rready) begin
                drop_w = ar_q.pop_front();
                r_hs_cnt++;
            end
            if (axi.arvalid && axi.arready) begin
                ar_q.push_back(axi.araddr);
                ar_hs_cnt++;
            end
        end
        #1;
        if (!reset && !r_hold && ar_q.size() != 0) begin
            axi.rvalid = 1'b1;
            axi.rdata  = rd_word(ar_q[0]);
        end else begin
            axi.rvalid = 1'b0;
            axi.rdata  = 32'd0;
        end
    end

    // Scoreboard: every data_ok must match the oldest accepted request.
    always @(negedge clk) begin
        if (!reset && sram.inst_sram_data_ok) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL data_ok_unexpected rdata=%h with no pending request", sram.inst_sram_rdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (sram.inst_sram_rdata !== exp_w) begin
                    bad++;
                    $display("FAIL data_order got=%h want=%h", sram.inst_sram_rdata, exp_w);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        bit got = 0;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = a;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sram.inst_sram_addr_ok === 1'b1) begin
                exp_q.push_back(rd_word(a));
                got = 1;
            end
            tick();
        end
        sram.inst_sram_req = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL issue_timeout addr=%h got=0 want=1", a); end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && axi.rready === 1'b0 && axi.arvalid === 1'b0) done = 1;
        end
        total++;
        if (!done) begin bad++; $display("FAIL drain_timeout pending=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        total++;
        if ({axi.arvalid, sram.inst_sram_data_ok, axi.rready} !== 3'b000 || axi.araddr !== 32'd0 ||
            axi.arsize !== 3'd0 || sram.inst_sram_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_state arvalid=%b data_ok=%b rready=%b araddr=%h arsize=%0d rdata=%h want all 0",
                     axi.arvalid, sram.inst_sram_data_ok, axi.rready, axi.araddr, axi.arsize, sram.inst_sram_rdata);
        end
        total++;
        if (dut.cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", dut.cnt); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (sram.inst_sram_addr_ok !== 1'b0) begin bad++; $display("FAIL idle_addr_ok got=%b want=0", sram.inst_sram_addr_ok); end
        sram.inst_sram_req = 1'b1;
        #1;
        total++;
        if (sram.inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL comb_addr_ok got=%b want=1", sram.inst_sram_addr_ok); end
        sram.inst_sram_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        axi.arready = 1'b1;
        r_hold = 1'b0;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0000;
        @(negedge clk);
        total++;
        if (sram.inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL single_addr_ok got=%b want=1", sram.inst_sram_addr_ok); end
        else exp_q.push_back(32'h0280_0c0c);
        tick();
        sram.inst_sram_req = 1'b0;
        @(negedge clk);
        total++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1c00_0000 || axi.arsize !== 3'd2) begin
            bad++;
            $display("FAIL single_ar arvalid=%b araddr=%h arsize=%0d want 1 1c000000 2", axi.arvalid, axi.araddr, axi.arsize);
        end
        total++;
        if ({axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot} !== {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0}) begin
            bad++;
            $display("FAIL ar_consts arid=%h arlen=%h arburst=%b arlock=%b arcache=%h arprot=%h want 0 0 01 00 0 0",
                     axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot);
        end
        tick();
        @(negedge clk);
        total++;
        if (axi.rvalid !== 1'b1 || axi.rready !== 1'b1 || sram.inst_sram_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL single_r rvalid=%b rready=%b data_ok=%b want 1 1 0", axi.rvalid, axi.rready, sram.inst_sram_data_ok);
        end
        tick();
        @(negedge clk);
        total++;
        if (sram.inst_sram_data_ok !== 1'b1 || sram.inst_sram_rdata !== 32'h0280_0c0c) begin
            bad++;
            $display("FAIL single_data data_ok=%b rdata=%h want 1 02800c0c", sram.inst_sram_data_ok, sram.inst_sram_rdata);
        end
        total++;
        if (dut.cnt !== 2'd0 || axi.rready !== 1'b0) begin
            bad++;
            $display("FAIL single_cnt cnt=%0d rready=%b want 0 0", dut.cnt, axi.rready);
        end
        wait_idle();
    endtask

    task automatic test_ar_stall();
        int hs0;
        axi.arready = 1'b0;
        r_hold = 1'b0;
        hs0 = ar_hs_cnt;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0010;
        @(negedge clk);
        total++;
        if (sram.inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", sram.inst_sram_addr_ok); end
        else exp_q.push_back(rd_word(32'h1c00_0010));
        tick();
        sram.inst_sram_addr = 32'h1c00_0014;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h1c00_0010 || sram.inst_sram_addr_ok !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d arvalid=%b araddr=%h addr_ok=%b want 1 1c000010 0",
                         i, axi.arvalid, axi.araddr, sram.inst_sram_addr_ok);
            end
            tick();
        end
        sram.inst_sram_req = 1'b0;
        axi.arready = 1'b1;
        wait_idle();
        total++;
        if (ar_hs_cnt - hs0 !== 1) begin bad++; $display("FAIL stall_ar_count got=%0d want=1", ar_hs_cnt - hs0); end
    endtask

    task automatic test_outstanding();
        bit got = 0;
        int r0;
        axi.arready = 1'b1;
        r_hold = 1'b1;
        issue(32'h1c00_0000);
        issue(32'h1c00_0004);
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (sram.inst_sram_addr_ok !== 1'b0 || dut.cnt !== 2'd2) begin
                bad++;
                $display("FAIL limit_hold cyc=%0d addr_ok=%b cnt=%0d want 0 2", i, sram.inst_sram_addr_ok, dut.cnt);
            end
            tick();
        end
        r0 = r_hs_cnt;
        r_hold = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (sram.inst_sram_addr_ok === 1'b1) begin
                exp_q.push_back(rd_word(32'h1c00_0008));
                got = 1;
                total++;
                if (r_hs_cnt - r0 !== 1) begin bad++; $display("FAIL limit_release r_beats=%0d want=1", r_hs_cnt - r0); end
            end
            tick();
        end
        sram.inst_sram_req = 1'b0;
        total++;
        if (!got) begin bad++; $display("FAIL limit_third_timeout got=0 want=1"); end
        wait_idle();
    endtask

    task automatic test_simultaneous();
        axi.arready = 1'b1;
        r_hold = 1'b0;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0040;
        @(negedge clk);
        total++;
        if (sram.inst_sram_addr_ok !== 1'b1) begin bad++; $display("FAIL simul_first got=%b want=1", sram.inst_sram_addr_ok); end
        else exp_q.push_back(rd_word(32'h1c00_0040));
        tick();
        sram.inst_sram_req = 1'b0;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0044;
        @(negedge clk);
        total++;
        if (sram.inst_sram_addr_ok !== 1'b1 || axi.rvalid !== 1'b1 || axi.rready !== 1'b1) begin
            bad++;
            $display("FAIL simul_overlap addr_ok=%b rvalid=%b rready=%b want 1 1 1",
                     sram.inst_sram_addr_ok, axi.rvalid, axi.rready);
        end else exp_q.push_back(rd_word(32'h1c00_0044));
        tick();
        sram.inst_sram_req = 1'b0;
        @(negedge clk);
        total++;
        if (dut.cnt !== 2'd1 || axi.rready !== 1'b1 || sram.inst_sram_data_ok !== 1'b1) begin
            bad++;
            $display("FAIL simul_cnt cnt=%0d rready=%b data_ok=%b want 1 1 1", dut.cnt, axi.rready, sram.inst_sram_data_ok);
        end
        wait_idle();
    endtask

    task automatic test_write_reject();
        int hs0;
        hs0 = ar_hs_cnt;
        tick();
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_wr   = 1'b1;
        sram.inst_sram_addr = 32'h1c00_0020;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (sram.inst_sram_addr_ok !== 1'b0 || axi.arvalid !== 1'b0) begin
                bad++;
                $display("FAIL wr_reject cyc=%0d addr_ok=%b arvalid=%b want 0 0", i, sram.inst_sram_addr_ok, axi.arvalid);
            end
            tick();
        end
        sram.inst_sram_req = 1'b0;
        sram.inst_sram_wr  = 1'b0;
        total++;
        if (ar_hs_cnt !== hs0) begin bad++; $display("FAIL wr_ar_count got=%0d want=0", ar_hs_cnt - hs0); end
    endtask

    task automatic test_reset_midflight();
        axi.arready = 1'b0;
        r_hold = 1'b0;
        issue(32'h1c00_0030);
        @(negedge clk);
        total++;
        if (axi.arvalid !== 1'b1 || dut.cnt !== 2'd1) begin
            bad++;
            $display("FAIL midrst_pre arvalid=%b cnt=%0d want 1 1", axi.arvalid, dut.cnt);
        end
        tick();
        reset = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        total++;
        if (axi.arvalid !== 1'b0 || dut.cnt !== 2'd0 || sram.inst_sram_data_ok !== 1'b0 || axi.rready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_post arvalid=%b cnt=%0d data_ok=%b rready=%b want 0 0 0 0",
                     axi.arvalid, dut.cnt, sram.inst_sram_data_ok, axi.rready);
        end
        tick();
        reset = 1'b0;
        axi.arready = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sram.inst_sram_req   = 1'b0;
        sram.inst_sram_wr    = 1'b0;
        sram.inst_sram_size  = 2'd2;
        sram.inst_sram_wstrb = 4'd0;
        sram.inst_sram_addr  = 32'd0;
        sram.inst_sram_wdata = 32'd0;
        axi.arready = 1'b0;
        axi.rid     = 4'd0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b1;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'd0;
        test_reset();
        test_single_fetch();
        test_ar_stall();
        test_outstanding();
        test_simultaneous();
        test_write_reject();
        test_reset_midflight();
        test_single_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
